multi_dataflow_engine_ctrl: RTL and testbench
=============================================

Name: multi_dataflow_engine_ctrl

Overview:
Engine-side controller that drives the kernel adapter's start control and consumes its ready/done/idle flags. It accepts a job (number of output elements), issues one kernel start per input group, counts output handshakes until the job completes, and reports busy/done/error to the HWPE control slave. A watchdog aborts a stalled job.

Parameters:
CNT_W, 32, width of job length and output/issue counters
TO_W, 16, width of the watchdog counter
TIMEOUT, 1024, cycles without kernel activity before abort; 0 disables the watchdog

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
job_start_i  in  1  single-cycle job trigger from the control slave
job_len_i  in  CNT_W  outputs expected for the job; sampled on an accepted job_start_i
clear_i  in  1  synchronous abort/soft clear
kernel_ready_i  in  1  adapter flags.ready (level: all input streams consumed one element)
kernel_done_i  in  1  adapter flags.done (one-cycle pulse per output handshake)
kernel_idle_i  in  1  adapter flags.idle
kernel_start_o  out  1  adapter ctrl.start, one-cycle pulse
job_busy_o  out  1  high while a job is active
job_done_o  out  1  one-cycle completion pulse
job_err_o  out  1  sticky watchdog error
out_cnt_o  out  CNT_W  outputs counted in the current/last job

Behaviour:
- Reset: state IDLE; all outputs 0; len, issue counter, out counter, watchdog and ready_q = 0.
- All outputs registered; no combinational input-to-output path.
- States: IDLE, START, COMPUTE, DONE.
- IDLE: job_busy_o=0. On job_start_i:
  - job_len_i != 0: latch len; clear out_cnt, issue counter, watchdog and job_err_o; go START.
  - job_len_i == 0: clear job_err_o and out_cnt; go DONE. Produces the done pulse with no kernel start.
- START: kernel_start_o=1 for exactly this cycle; issue counter := 1; go COMPUTE. job_busy_o=1 from START through DONE.
- COMPUTE:
  - ready_q registers kernel_ready_i. A ready event is kernel_ready_i & ~ready_q (rising edge only), because the adapter's ready level stays high until the start clears it.
  - On a ready event with issue < len: kernel_start_o=1 on the next cycle; issue increments.
  - On a ready event with issue == len: the event is ignored.
  - On kernel_done_i: out_cnt increments.
  - When out_cnt reaches len (including on the increment cycle): go DONE next cycle. Further starts are suppressed from that cycle.
  - A ready event and kernel_done_i in the same cycle are both processed.
- DONE: job_done_o=1 for one cycle; go IDLE. out_cnt_o holds its value until the next accepted job.
- Watchdog (TIMEOUT != 0, COMPUTE only):
  - Increments every cycle; cleared on a ready event, on kernel_done_i, or on kernel_start_o.
  - At TIMEOUT: job_err_o := 1; go DONE (done pulse still emitted).
  - job_err_o stays set until the next accepted job_start_i, clear_i, or reset.
- kernel_done_i outside COMPUTE is ignored; kernel_idle_i is informational only and does not gate transitions.
- job_start_i while job_busy_o=1 is ignored; len is not re-sampled.
- clear_i, any state, highest synchronous priority:
  - Next state IDLE; counters and job_err_o cleared.
  - No job_done_o and no kernel_start_o in that cycle.
  - clear_i and job_start_i together: clear wins; the job is not accepted.
- Reset mid-job: immediate return to reset values; any in-flight kernel_start_o is dropped.
- Counters are CNT_W-bit unsigned, compared with ==, and cannot wrap because issue and out saturate at len.

Test Plan:
- len=3; ready rises 2 cycles after each start; done pulses follow. Expect 3 kernel_start_o pulses, out_cnt_o 0→1→2→3, one job_done_o the cycle after DONE is entered, busy low afterwards, err=0.
- len=0 start. Expect no kernel_start_o, job_done_o exactly 2 cycles after job_start_i, out_cnt_o=0.
- len=2, TIMEOUT=16; after the first done, the kernel goes silent. Expect job_err_o=1 and job_done_o 16 cycles after the last activity, out_cnt_o=1; next job_start_i clears err.
- len=4; ready held high for 5 cycles after a start. Expect exactly one extra start (edge-detected). Ready rise coincident with done: both counted.
- len=5; clear_i asserted at out_cnt=2 together with job_start_i. Expect IDLE next cycle, no done pulse, out_cnt_o=0, job not accepted. job_start_i while busy on a separate run: ignored.
- len=3; rst_i asserted mid-COMPUTE for 1 cycle. Expect all outputs 0 immediately (asynchronous), state IDLE, no start after release until a new job_start_i.

Source files
------------

// File: rtl/multi_dataflow_engine_ctrl.sv
// Engine-side job controller: issues kernel starts per ready edge, counts output handshakes, aborts stalled jobs.
// Latency: job_start_i to first kernel_start_o is 1 cycle; job_done_o follows DONE state entry by 1 cycle.
// Backpressure: one start per ready rising edge; job_start_i is ignored while busy; clear_i overrides everything.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   job_start_i/job_len_i job trigger and expected output count (len 0 completes immediately)
//   clear_i               synchronous abort, highest priority
//   kernel_ready_i/done_i/idle_i  adapter flags (idle is informational only)
//   kernel_start_o        one-cycle adapter start pulse
//   job_busy_o/done_o/err_o, out_cnt_o  status to the control slave
module multi_dataflow_engine_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TO_W    = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             job_start_i,
    input  logic [CNT_W-1:0] job_len_i,
    input  logic             clear_i,
    input  logic             kernel_ready_i,
    input  logic             kernel_done_i,
    input  logic             kernel_idle_i,
    output logic             kernel_start_o,
    output logic             job_busy_o,
    output logic             job_done_o,
    output logic             job_err_o,
    output logic [CNT_W-1:0] out_cnt_o
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        COMPUTE,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] len, len_nxt;
    logic [CNT_W-1:0] issue, issue_nxt;
    logic [CNT_W-1:0] out_nxt, out_inc;
    logic [TO_W-1:0]  wdog, wdog_nxt;
    logic             ready_q;
    logic             ready_ev;
    logic             activity;
    logic             start_nxt, done_nxt, err_nxt;

    // kernel_idle_i carries no control meaning here; kept visible for debug only.
    logic unused_idle;
    assign unused_idle = kernel_idle_i;

    // The adapter holds ready high until it sees a start, so only the rising edge is an event.
    assign ready_ev = kernel_ready_i & ~ready_q;
    assign activity = ready_ev | kernel_done_i | kernel_start_o;
    assign out_inc  = out_cnt_o + CNT_W'(kernel_done_i);

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        issue_nxt = issue;
        out_nxt   = out_cnt_o;
        wdog_nxt  = wdog;
        start_nxt = 1'b0;
        err_nxt   = job_err_o;
        // Done is registered off the DONE state, so it lands one cycle after DONE is entered.
        done_nxt  = (state == DONE);

        case (state)
            IDLE: begin
                if (job_start_i) begin
                    out_nxt = '0;
                    err_nxt = 1'b0;
                    if (job_len_i != '0) begin
                        len_nxt   = job_len_i;
                        issue_nxt = '0;
                        wdog_nxt  = '0;
                        start_nxt = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            START: begin
                issue_nxt = CNT_W'(1);
                state_nxt = COMPUTE;
            end
            COMPUTE: begin
                out_nxt = out_inc;
                if (out_inc == len) begin
                    // Completion suppresses any start that a same-cycle ready edge would give.
                    state_nxt = DONE;
                end else begin
                    if (ready_ev && (issue != len)) begin
                        start_nxt = 1'b1;
                        issue_nxt = issue + CNT_W'(1);
                    end
                    if (TIMEOUT != 0) begin
                        if (activity) begin
                            wdog_nxt = '0;
                        end else if (wdog == TO_W'(TIMEOUT - 1)) begin
                            err_nxt   = 1'b1;
                            state_nxt = DONE;
                        end else begin
                            wdog_nxt = wdog + TO_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort wins over any accepted job, issued start or pending done pulse.
        if (clear_i) begin
            state_nxt = IDLE;
            len_nxt   = '0;
            issue_nxt = '0;
            out_nxt   = '0;
            wdog_nxt  = '0;
            err_nxt   = 1'b0;
            start_nxt = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            len            <= '0;
            issue          <= '0;
            out_cnt_o      <= '0;
            wdog           <= '0;
            ready_q        <= 1'b0;
            kernel_start_o <= 1'b0;
            job_busy_o     <= 1'b0;
            job_done_o     <= 1'b0;
            job_err_o      <= 1'b0;
        end else begin
            state          <= state_nxt;
            len            <= len_nxt;
            issue          <= issue_nxt;
            out_cnt_o      <= out_nxt;
            wdog           <= wdog_nxt;
            ready_q        <= kernel_ready_i;
            kernel_start_o <= start_nxt;
            job_busy_o     <= (state_nxt != IDLE);
            job_done_o     <= done_nxt;
            job_err_o      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_multi_dataflow_engine_ctrl.sv
// Self-checking bench: a small kernel model reacts to kernel_start_o; per-job expectations go into a
// scoreboard queue when the job is launched and are popped when job_done_o is observed.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_multi_dataflow_engine_ctrl;

    localparam int CNT_W   = 32;
    localparam int TO_W    = 16;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             job_start_i;
    logic [CNT_W-1:0] job_len_i;
    logic             clear_i;
    logic             kernel_ready_i;
    logic             kernel_done_i;
    logic             kernel_idle_i;
    logic             kernel_start_o;
    logic             job_busy_o;
    logic             job_done_o;
    logic             job_err_o;
    logic [CNT_W-1:0] out_cnt_o;

    always #5 clk = ~clk;

    multi_dataflow_engine_ctrl #(
        .CNT_W  (CNT_W),
        .TO_W   (TO_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .job_start_i   (job_start_i),
        .job_len_i     (job_len_i),
        .clear_i       (clear_i),
        .kernel_ready_i(kernel_ready_i),
        .kernel_done_i (kernel_done_i),
        .kernel_idle_i (kernel_idle_i),
        .kernel_start_o(kernel_start_o),
        .job_busy_o    (job_busy_o),
        .job_done_o    (job_done_o),
        .job_err_o     (job_err_o),
        .out_cnt_o     (out_cnt_o)
    );

    typedef struct {
        int out;
        int err;
        int starts;
    } exp_t;

    exp_t exp_q[$];
    int   ready_due[$];
    int   done_due[$];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_starts = 0, n_done = 0, job_starts = 0;
    int   rdy_dly = 2, done_dly = 3, done_budget = 0;
    int   hold_req = 0, hold_cnt = 0, hold_starts = 0;
    bit   drop_pending = 0, silent = 0, silence_after_done = 0, model_on = 0;
    logic [CNT_W-1:0] prev_out = '0;
    logic prev_err = 1'b0;
    int   out_change_cyc = 0, done_cyc = 0, err_rise_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One clock: observe outputs, feed the scoreboard, then drive the next-cycle inputs.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (kernel_start_o) begin
            n_starts++;
            job_starts++;
            if (model_on && !silent) begin
                if (hold_cnt > 0) begin
                    drop_pending = 1;
                end else begin
                    kernel_ready_i = 1'b0;
                    ready_due.push_back(cyc + rdy_dly);
                end
                if (done_budget > 0) begin
                    done_due.push_back(cyc + done_dly);
                    done_budget--;
                end
            end
        end
        if (out_cnt_o != prev_out) begin
            if (out_cnt_o != '0) chk("out_step", out_cnt_o, prev_out + 1);
            out_change_cyc = cyc;
            prev_out       = out_cnt_o;
        end
        if (job_err_o && !prev_err) err_rise_cyc = cyc;
        prev_err = job_err_o;
        if (job_done_o) begin
            n_done++;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("done_without_job", job_done_o, 0);
            end else begin
                e = exp_q.pop_front();
                chk("done_out_cnt", out_cnt_o, e.out);
                chk("done_err", job_err_o, e.err);
                chk("done_starts", job_starts, e.starts);
                chk("done_busy_low", job_busy_o, 0);
            end
        end

        job_start_i   = 1'b0;
        clear_i       = 1'b0;
        kernel_done_i = 1'b0;
        if (model_on && !silent) begin
            if (done_due.size() > 0 && done_due[0] == cyc + 1) begin
                void'(done_due.pop_front());
                kernel_done_i = 1'b1;
                if (silence_after_done) silent = 1;
            end
            if (ready_due.size() > 0 && ready_due[0] == cyc + 1) begin
                void'(ready_due.pop_front());
                kernel_ready_i = 1'b1;
                if (hold_req > 0) begin
                    hold_cnt = hold_req;
                    hold_req = 0;
                end
            end else if (hold_cnt > 0) begin
                hold_cnt--;
                if (hold_cnt == 0) begin
                    hold_starts = job_starts;
                    if (drop_pending) begin
                        drop_pending   = 0;
                        kernel_ready_i = 1'b0;
                        ready_due.push_back(cyc + rdy_dly);
                    end
                end
            end
        end
    endtask

    task automatic model_reset();
        ready_due.delete();
        done_due.delete();
        kernel_ready_i     = 1'b0;
        kernel_done_i      = 1'b0;
        hold_cnt           = 0;
        hold_req           = 0;
        drop_pending       = 0;
        silent             = 0;
        silence_after_done = 0;
        model_on           = 1;
        repeat (3) step();
    endtask

    task automatic start_job(input int len, input int e_out, input int e_err, input int e_starts);
        exp_t e;
        e.out       = e_out;
        e.err       = e_err;
        e.starts    = e_starts;
        exp_q.push_back(e);
        job_starts  = 0;
        job_len_i   = 32'(len);
        job_start_i = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n0 = n_done;
        int k = 0;
        while (n_done == n0 && k < budget) begin
            step();
            k++;
        end
        chk(tag, n_done - n0, 1);
    endtask

    task automatic wait_out(input string tag, input int target, input int budget);
        int k = 0;
        while (out_cnt_o != 32'(target) && k < budget) begin
            step();
            k++;
        end
        chk(tag, out_cnt_o, target);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int s, ns, nd;
        rst_i = 1'b1; job_start_i = 1'b0; job_len_i = '0; clear_i = 1'b0;
        kernel_ready_i = 1'b0; kernel_done_i = 1'b0; kernel_idle_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_start", kernel_start_o, 0);
        chk("rst_busy", job_busy_o, 0);
        chk("rst_done", job_done_o, 0);
        chk("rst_err", job_err_o, 0);
        chk("rst_out", out_cnt_o, 0);
        rst_i = 1'b0;

        // len=3, ready 2 cycles after each start; done of one start coincides with next ready rise.
        model_reset();
        rdy_dly = 2; done_dly = 4; done_budget = 3;
        start_job(3, 3, 0, 3);
        wait_done("t1_done_seen", 100);
        nd = n_done;
        repeat (4) step();
        chk("t1_single_done", n_done, nd);
        chk("t1_busy_after", job_busy_o, 0);

        // len=0: immediate completion without a kernel start.
        model_reset();
        s = cyc;
        start_job(0, 0, 0, 0);
        step();
        chk("t2_busy", job_busy_o, 1);
        wait_done("t2_done_seen", 10);
        chk("t2_done_latency", done_cyc - s, 2);

        // len=2: kernel goes silent after the first output; watchdog aborts.
        model_reset();
        rdy_dly = 2; done_dly = 3; done_budget = 1; silence_after_done = 1;
        start_job(2, 1, 1, 2);
        wait_done("t3_done_seen", 100);
        chk("t3_err_delay", err_rise_cyc - out_change_cyc, TIMEOUT);
        chk("t3_done_after_err", done_cyc - err_rise_cyc, 1);
        chk("t3_err_sticky", job_err_o, 1);

        // len=4 with ready held high for several cycles: one start per rising edge only.
        model_reset();
        chk("t4_err_before", job_err_o, 1);
        rdy_dly = 2; done_dly = 3; done_budget = 4; hold_req = 5;
        start_job(4, 4, 0, 4);
        step();
        chk("t4_err_cleared", job_err_o, 0);
        wait_done("t4_done_seen", 200);
        chk("t4_hold_starts", hold_starts, 2);

        // len=5, clear together with a new job at out_cnt=2: abort, new job rejected.
        model_reset();
        rdy_dly = 2; done_dly = 3; done_budget = 5;
        start_job(5, 5, 0, 5);
        wait_out("t5_reach2", 2, 100);
        exp_q.delete();
        clear_i     = 1'b1;
        job_start_i = 1'b1;
        job_len_i   = 32'd7;
        step();
        model_on = 0;
        kernel_ready_i = 1'b0;
        chk("t5_busy", job_busy_o, 0);
        chk("t5_out", out_cnt_o, 0);
        chk("t5_err", job_err_o, 0);
        ns = n_starts; nd = n_done;
        repeat (20) step();
        chk("t5_no_start", n_starts, ns);
        chk("t5_no_done", n_done, nd);

        // job_start_i while busy is ignored and len is not re-sampled.
        model_reset();
        rdy_dly = 2; done_dly = 3; done_budget = 3;
        start_job(3, 3, 0, 3);
        step();
        step();
        job_start_i = 1'b1;
        job_len_i   = 32'd9;
        wait_done("t6_done_seen", 100);
        nd = n_done;
        repeat (6) step();
        chk("t6_ignored_start", n_done, nd);

        // Asynchronous reset mid-COMPUTE.
        model_reset();
        rdy_dly = 2; done_dly = 3; done_budget = 3;
        start_job(3, 3, 0, 3);
        wait_out("t7_reach1", 1, 100);
        #2 rst_i = 1'b1;
        #1;
        chk("t7_rst_start", kernel_start_o, 0);
        chk("t7_rst_busy", job_busy_o, 0);
        chk("t7_rst_done", job_done_o, 0);
        chk("t7_rst_err", job_err_o, 0);
        chk("t7_rst_out", out_cnt_o, 0);
        exp_q.delete();
        model_on = 0;
        kernel_ready_i = 1'b0;
        kernel_done_i  = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        ns = n_starts; nd = n_done;
        repeat (20) step();
        chk("t7_no_start", n_starts, ns);
        chk("t7_no_done", n_done, nd);
        chk("t7_idle", job_busy_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
